// File: rtl/t03_wb_pkg.sv
// Shared widths, write-source encoding and the operand-hazard compare helper
// for the writeback scheduler.
package t03_wb_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned REG_ADDR_W    = 5;
  localparam int unsigned WB_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_LOAD,
    SRC_FIFO,
    SRC_ALU
  } wb_src_e;

  // x0 is never a hazard: it is hardwired and its writes are dropped.
  function automatic logic rd_match(input logic [REG_ADDR_W-1:0] rs,
                                    input logic [REG_ADDR_W-1:0] rd,
                                    input logic                  en);
    return en && (rs != '0) && (rs == rd);
  endfunction

endpackage

// File: rtl/t03_wb_fifo.sv
// In-order queue of deferred ALU writebacks; entry destinations and valid bits are
// exposed so the decode stage can detect hazards against queued writes.
module t03_wb_fifo
  import t03_wb_pkg::*;
(
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic                                       push,
  input  logic                                       pop,
  input  logic [REG_ADDR_W-1:0]                      push_rd,
  input  logic [DATA_W-1:0]                          push_data,
  output logic                                       full,
  output logic                                       empty,
  output logic [REG_ADDR_W-1:0]                      head_rd,
  output logic [DATA_W-1:0]                          head_data,
  output logic [WB_FIFO_DEPTH-1:0][REG_ADDR_W-1:0]   entry_rd,
  output logic [WB_FIFO_DEPTH-1:0]                   entry_valid
);

  // Depth must be a power of two so the pointers wrap naturally.
  localparam int unsigned PTR_W = (WB_FIFO_DEPTH > 1) ? $clog2(WB_FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(WB_FIFO_DEPTH + 1);

  logic [REG_ADDR_W-1:0] mem_rd_q   [WB_FIFO_DEPTH];
  logic [DATA_W-1:0]     mem_data_q [WB_FIFO_DEPTH];
  logic [PTR_W-1:0]      rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  push_ok, pop_ok;

  assign full      = (count_q == CNT_W'(WB_FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign push_ok   = push && !full;
  assign pop_ok    = pop && !empty;
  assign head_rd   = mem_rd_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        mem_rd_q[i]   <= '0;
        mem_data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_rd_q[wr_ptr_q]   <= push_rd;
        mem_data_q[wr_ptr_q] <= push_data;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
        count_q <= count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  always_comb begin
    logic [PTR_W-1:0] offset;
    offset      = '0;
    entry_rd    = '0;
    entry_valid = '0;
    for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
      offset         = PTR_W'(i) - rd_ptr_q;
      entry_rd[i]    = mem_rd_q[i];
      entry_valid[i] = (CNT_W'(offset) < count_q);
    end
  end

endmodule

// File: rtl/t03_wb_scheduler.sv
// Register-file writeback arbiter: load return > queued ALU write > incoming ALU write,
// with single-outstanding-load tracking and decode-stage hazard detection.
module t03_wb_scheduler
  import t03_wb_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  alu_valid,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0]     alu_data,
  output logic                  alu_ready,
  input  logic                  ld_issue,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic                  ld_ret_valid,
  input  logic [DATA_W-1:0]     ld_ret_data,
  output logic                  ld_busy,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  output logic                  stall,
  output logic                  rf_we,
  output logic [REG_ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0]     rf_wdata,
  output logic                  protocol_err
);

  logic                  ld_busy_q, ld_busy_d;
  logic [REG_ADDR_W-1:0] ld_rd_q, ld_rd_d;
  logic                  protocol_err_q, protocol_err_d;
  logic                  rf_we_q;
  logic [REG_ADDR_W-1:0] rf_waddr_q;
  logic [DATA_W-1:0]     rf_wdata_q;

  logic                  ret_ok, issue_ok, load_wr, alu_wr;
  logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [REG_ADDR_W-1:0] fifo_head_rd;
  logic [DATA_W-1:0]     fifo_head_data;
  logic [WB_FIFO_DEPTH-1:0][REG_ADDR_W-1:0] fifo_entry_rd;
  logic [WB_FIFO_DEPTH-1:0]                 fifo_entry_valid;
  wb_src_e               src;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]     wr_data;

  assign ret_ok   = ld_ret_valid && ld_busy_q;
  // A same-cycle return frees the slot, so back-to-back loads are legal.
  assign issue_ok = ld_issue && (!ld_busy_q || ld_ret_valid);
  assign load_wr  = ret_ok && (ld_rd_q != '0);

  // Refusing an ALU write to the pending load rd keeps the older load from clobbering it.
  assign alu_ready = !fifo_full && !(ld_busy_q && (alu_rd == ld_rd_q));
  assign alu_wr    = alu_valid && alu_ready && (alu_rd != '0);
  assign fifo_pop  = !load_wr && !fifo_empty;
  assign fifo_push = alu_wr && (load_wr || !fifo_empty);

  always_comb begin
    src = SRC_NONE;
    if (load_wr)          src = SRC_LOAD;
    else if (!fifo_empty) src = SRC_FIFO;
    else if (alu_wr)      src = SRC_ALU;
  end

  always_comb begin
    wr_addr = rf_waddr_q;
    wr_data = rf_wdata_q;
    unique case (src)
      SRC_LOAD: begin wr_addr = ld_rd_q;      wr_data = ld_ret_data;    end
      SRC_FIFO: begin wr_addr = fifo_head_rd; wr_data = fifo_head_data; end
      SRC_ALU:  begin wr_addr = alu_rd;       wr_data = alu_data;       end
      default:  ;
    endcase
  end

  always_comb begin
    ld_busy_d      = ld_busy_q;
    ld_rd_d        = ld_rd_q;
    protocol_err_d = protocol_err_q
                     | (ld_ret_valid && !ld_busy_q)
                     | (ld_issue && ld_busy_q && !ld_ret_valid);
    if (issue_ok) begin
      ld_busy_d = 1'b1;
      ld_rd_d   = ld_rd;
    end else if (ret_ok) begin
      ld_busy_d = 1'b0;
    end
  end

  always_comb begin
    stall = 1'b0;
    for (int s = 0; s < 2; s++) begin
      logic [REG_ADDR_W-1:0] rs;
      rs = (s == 0) ? rs1 : rs2;
      stall = stall | rd_match(rs, ld_rd_q, ld_busy_q)
                    | rd_match(rs, rf_waddr_q, rf_we_q)
                    | rd_match(rs, alu_rd, alu_valid);
      for (int i = 0; i < WB_FIFO_DEPTH; i++) begin
        stall = stall | rd_match(rs, fifo_entry_rd[i], fifo_entry_valid[i]);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_busy_q      <= 1'b0;
      ld_rd_q        <= '0;
      protocol_err_q <= 1'b0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
    end else begin
      ld_busy_q      <= ld_busy_d;
      ld_rd_q        <= ld_rd_d;
      protocol_err_q <= protocol_err_d;
      rf_we_q        <= (src != SRC_NONE);
      rf_waddr_q     <= wr_addr;
      rf_wdata_q     <= wr_data;
    end
  end

  assign ld_busy      = ld_busy_q;
  assign protocol_err = protocol_err_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;

  t03_wb_fifo u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .pop         (fifo_pop),
    .push_rd     (alu_rd),
    .push_data   (alu_data),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head_rd     (fifo_head_rd),
    .head_data   (fifo_head_data),
    .entry_rd    (fifo_entry_rd),
    .entry_valid (fifo_entry_valid)
  );

endmodule

// File: tb/tb_t03_wb_scheduler.sv
// Directed checks of writeback priority, load tracking, hazards, x0 handling and reset.
module tb_t03_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue;
  logic [4:0]  ld_rd;
  logic        ld_ret_valid;
  logic [31:0] ld_ret_data;
  logic        ld_busy;
  logic [4:0]  rs1, rs2;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        protocol_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  t03_wb_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .ld_issue     (ld_issue),
    .ld_rd        (ld_rd),
    .ld_ret_valid (ld_ret_valid),
    .ld_ret_data  (ld_ret_data),
    .ld_busy      (ld_busy),
    .rs1          (rs1),
    .rs2          (rs2),
    .stall        (stall),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    ld_issue = 0; ld_rd = 0; ld_ret_valid = 0; ld_ret_data = 0;
    rs1 = 0; rs2 = 0;
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    tick();
    tick();
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_ld_busy", ld_busy, 0);
    chk("rst_perr", protocol_err, 0);
    chk("rst_alu_ready", alu_ready, 1);
    chk("rst_stall", stall, 0);
    reset = 0;
    tick();

    // ALU write x5 with idle load path
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234; #1;
    chk("alu5_ready", alu_ready, 1);
    tick();
    idle_inputs(); rs1 = 5; #1;
    chk("alu5_we", rf_we, 1);
    chk("alu5_waddr", rf_waddr, 5);
    chk("alu5_wdata", rf_wdata, 32'h1234);
    chk("alu5_stall_rf", stall, 1);
    tick();
    chk("alu5_we_low", rf_we, 0);
    chk("alu5_waddr_hold", rf_waddr, 5);
    chk("alu5_wdata_hold", rf_wdata, 32'h1234);
    chk("alu5_stall_clear", stall, 0);
    rs1 = 0;

    // Load x7 returns alongside ALU x3, then ALU x4
    ld_issue = 1; ld_rd = 7;
    tick();
    ld_issue = 0;
    chk("ld7_busy", ld_busy, 1);
    ld_ret_valid = 1; ld_ret_data = 32'hDEAD;
    alu_valid = 1; alu_rd = 3; alu_data = 32'h3333; #1;
    chk("x3_ready", alu_ready, 1);
    tick();
    chk("x7_we", rf_we, 1);
    chk("x7_waddr", rf_waddr, 7);
    chk("x7_wdata", rf_wdata, 32'hDEAD);
    chk("x7_busy_clear", ld_busy, 0);
    ld_ret_valid = 0; alu_rd = 4; alu_data = 32'h4444; #1;
    chk("x4_ready", alu_ready, 1);
    tick();
    chk("x3_we", rf_we, 1);
    chk("x3_waddr", rf_waddr, 3);
    chk("x3_wdata", rf_wdata, 32'h3333);
    idle_inputs(); rs2 = 4; #1;
    chk("x4_queued_stall", stall, 1);
    tick();
    chk("x4_we", rf_we, 1);
    chk("x4_waddr", rf_waddr, 4);
    chk("x4_wdata", rf_wdata, 32'h4444);
    rs2 = 0;
    tick();
    chk("x4_we_low", rf_we, 0);

    // Pending load x9 hazards
    ld_issue = 1; ld_rd = 9;
    tick();
    ld_issue = 0; rs1 = 9; #1;
    chk("x9_stall_busy", stall, 1);
    alu_valid = 1; alu_rd = 9; alu_data = 32'h5555; #1;
    chk("x9_alu_waw_block", alu_ready, 0);
    tick();
    chk("x9_no_alu_write", rf_we, 0);
    alu_valid = 0; ld_ret_valid = 1; ld_ret_data = 32'h9999; #1;
    chk("x9_stall_ret", stall, 1);
    tick();
    chk("x9_we", rf_we, 1);
    chk("x9_waddr", rf_waddr, 9);
    chk("x9_wdata", rf_wdata, 32'h9999);
    ld_ret_valid = 0; #1;
    chk("x9_stall_rf", stall, 1);
    tick();
    chk("x9_stall_gone", stall, 0);
    rs1 = 0;

    // Writes to x0 are dropped; rs1=0 never stalls
    alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFF; rs1 = 0; #1;
    chk("x0_ready", alu_ready, 1);
    chk("x0_stall", stall, 0);
    tick();
    idle_inputs();
    chk("x0_no_we", rf_we, 0);

    // Stray load return sets a sticky error; reset clears it
    ld_ret_valid = 1; ld_ret_data = 32'hBAD0;
    tick();
    ld_ret_valid = 0;
    chk("perr_set", protocol_err, 1);
    chk("perr_no_we", rf_we, 0);
    tick();
    chk("perr_sticky", protocol_err, 1);
    reset = 1; #1;
    chk("perr_reset", protocol_err, 0);
    tick();
    reset = 0;
    tick();

    // Back-to-back loads fill the FIFO, then reset mid-stream
    ld_issue = 1; ld_rd = 12;
    tick();
    ld_ret_valid = 1; ld_ret_data = 32'hC0C0; ld_rd = 13;
    alu_valid = 1; alu_rd = 10; alu_data = 32'hAAAA;
    tick();
    chk("x12_waddr", rf_waddr, 12);
    chk("reissue_busy", ld_busy, 1);
    ld_issue = 0; ld_ret_data = 32'hD0D0;
    alu_rd = 11; alu_data = 32'hBBBB;
    tick();
    chk("x13_waddr", rf_waddr, 13);
    chk("x13_wdata", rf_wdata, 32'hD0D0);
    chk("x13_busy_clear", ld_busy, 0);
    ld_ret_valid = 0; alu_rd = 14; alu_data = 32'hEEEE; rs1 = 10; #1;
    chk("full_not_ready", alu_ready, 0);
    chk("full_stall", stall, 1);
    alu_valid = 0; reset = 1; #1;
    chk("midrst_we", rf_we, 0);
    chk("midrst_busy", ld_busy, 0);
    chk("midrst_ready", alu_ready, 1);
    chk("midrst_fifo_empty_stall", stall, 0);
    tick();
    reset = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("post_rst_no_we", rf_we, 0);
    end
    ld_ret_valid = 1;
    tick();
    ld_ret_valid = 0;
    chk("late_ret_perr", protocol_err, 1);
    chk("late_ret_no_we", rf_we, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
